// File: rtl/dma_pkg.sv
// Shared definitions for the DMA transfer sequencer.
// Holds the FSM state encoding, configuration register selects and
// ctrl register bit positions used by the sequencer and its arbiter.
package dma_pkg;

  localparam int unsigned CFG_AW = 2;
  localparam int unsigned CTRL_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HOLD  = 3'd1,
    ST_READ  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Configuration register selects
  localparam logic [CFG_AW-1:0] CFG_SRC  = 2'd0;
  localparam logic [CFG_AW-1:0] CFG_DEST = 2'd1;
  localparam logic [CFG_AW-1:0] CFG_CNT  = 2'd2;
  localparam logic [CFG_AW-1:0] CFG_CTRL = 2'd3;

  // ctrl register bit positions
  localparam int unsigned CTRL_M2M   = 0;
  localparam int unsigned CTRL_DIR   = 1;
  localparam int unsigned CTRL_START = 2;

endpackage

// File: rtl/dma_arbiter.sv
// Two-input DMA request arbiter.
// Ports:
//   clk, rst_n  clock and async active-low reset
//   req         request vector (bit0 = IO1, bit1 = IO2)
//   update      a grant is being taken this cycle; remember its winner
//   grant_c     combinational one-hot grant for the current requests
module dma_arbiter #(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant_c
);

  // Index of the channel granted most recently; resets to channel 1 so
  // channel 0 wins the first contention.
  logic last_grant;

  // Grant selection: single requester wins, contention resolved by mode
  always_comb begin
    grant_c = 2'b00;
    case (req)
      2'b01:   grant_c = 2'b01;
      2'b10:   grant_c = 2'b10;
      2'b11: begin
        if (ROUND_ROBIN && !last_grant) grant_c = 2'b10;
        else                            grant_c = 2'b01;
      end
      default: grant_c = 2'b00;
    endcase
  end

  // Remember the winner of each taken grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (update && (grant_c != 2'b00)) begin
      last_grant <= grant_c[1];
    end
  end

endmodule

// File: rtl/dma_transfer_sequencer.sv
// Single-engine DMA transfer sequencer.
// Arbitrates two IO DMA requests, obtains the bus through an HREQ/HACK
// hold handshake and runs read/write word cycles between memory and IO,
// or memory-to-memory block copies.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   cfg_we/cfg_addr/cfg_wdata    processor config writes (ignored while busy)
//   dreq/dack                    IO DMA request / one-hot acknowledge
//   hreq/hack                    bus hold request / acknowledge
//   ab, db_in, db_out, db_oe     address bus, read data, write data + valid
//   mem_en, mem_rd               memory strobe and direction
//   io_en, io_rd                 IO1/IO2 strobes and direction
//   word_count, busy, tc         status: remaining words, active, terminal count
module dma_transfer_sequencer
  import dma_pkg::*;
#(
  parameter int unsigned AW          = 8,
  parameter int unsigned DW          = 8,
  parameter bit          ROUND_ROBIN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_addr,
  input  logic [DW-1:0]     cfg_wdata,
  input  logic [1:0]        dreq,
  output logic [1:0]        dack,
  output logic              hreq,
  input  logic              hack,
  output logic [AW-1:0]     ab,
  input  logic [DW-1:0]     db_in,
  output logic [DW-1:0]     db_out,
  output logic              db_oe,
  output logic              mem_en,
  output logic              mem_rd,
  output logic [1:0]        io_en,
  output logic              io_rd,
  output logic [AW-1:0]     word_count,
  output logic              busy,
  output logic              tc
);

  state_t              state, state_nxt;
  logic [AW-1:0]       src, src_nxt;
  logic [AW-1:0]       dest, dest_nxt;
  logic [AW-1:0]       count, count_nxt;
  logic [CTRL_W-1:0]   ctrl, ctrl_nxt;
  logic [DW-1:0]       data_reg, data_nxt;
  logic [1:0]          gnt, gnt_nxt;
  logic [1:0]          arb_grant_c;
  logic                arb_update;

  logic [1:0]          dack_nxt;
  logic                hreq_nxt;
  logic [AW-1:0]       ab_nxt;
  logic [DW-1:0]       db_out_nxt;
  logic                db_oe_nxt;
  logic                mem_en_nxt;
  logic                mem_rd_nxt;
  logic [1:0]          io_en_nxt;
  logic                io_rd_nxt;
  logic                busy_nxt;
  logic                tc_nxt;

  logic                m2m;
  logic                mem_src;
  logic                mem_dst;

  assign m2m     = ctrl[CTRL_M2M];
  // Memory is the read side for mem->IO and mem2mem, the write side for
  // IO->mem and mem2mem.
  assign mem_src = ctrl[CTRL_M2M] | ctrl[CTRL_DIR];
  assign mem_dst = ctrl[CTRL_M2M] | ~ctrl[CTRL_DIR];

  assign word_count = count;

  dma_arbiter #(
    .ROUND_ROBIN (ROUND_ROBIN)
  ) u_arbiter (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (dreq),
    .update  (arb_update),
    .grant_c (arb_grant_c)
  );

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      src      <= '0;
      dest     <= '0;
      count    <= '0;
      ctrl     <= '0;
      data_reg <= '0;
      gnt      <= '0;
    end else begin
      state    <= state_nxt;
      src      <= src_nxt;
      dest     <= dest_nxt;
      count    <= count_nxt;
      ctrl     <= ctrl_nxt;
      data_reg <= data_nxt;
      gnt      <= gnt_nxt;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_nxt  = state;
    src_nxt    = src;
    dest_nxt   = dest;
    count_nxt  = count;
    ctrl_nxt   = ctrl;
    data_nxt   = data_reg;
    gnt_nxt    = gnt;
    arb_update = 1'b0;

    if ((state == ST_IDLE) && cfg_we) begin
      case (cfg_addr)
        CFG_SRC:  src_nxt   = AW'(cfg_wdata);
        CFG_DEST: dest_nxt  = AW'(cfg_wdata);
        CFG_CNT:  count_nxt = AW'(cfg_wdata);
        default:  ctrl_nxt  = cfg_wdata[CTRL_W-1:0];
      endcase
    end

    case (state)
      ST_IDLE: begin
        if (count != '0) begin
          if (m2m) begin
            if (ctrl[CTRL_START]) begin
              state_nxt = ST_HOLD;
              gnt_nxt   = 2'b00;
            end
          end else if (dreq != 2'b00) begin
            state_nxt  = ST_HOLD;
            gnt_nxt    = arb_grant_c;
            arb_update = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        // A withdrawn IO request abandons the hold before any bus cycle
        if (!m2m && ((dreq & gnt) == 2'b00)) state_nxt = ST_IDLE;
        else if (hack)                       state_nxt = ST_READ;
      end
      ST_READ: begin
        data_nxt  = db_in;
        state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        count_nxt = count - AW'(1);
        if (mem_src) src_nxt  = src + AW'(1);
        if (mem_dst) dest_nxt = dest + AW'(1);
        if (count_nxt == '0) state_nxt = ST_DONE;
        else if (m2m)        state_nxt = ST_READ;
        else                 state_nxt = ST_IDLE;
      end
      ST_DONE: begin
        ctrl_nxt[CTRL_START] = 1'b0;
        state_nxt            = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Bus strobes for the state being entered, so they are registered and
  // line up with that state's cycle.
  always_comb begin
    dack_nxt   = 2'b00;
    ab_nxt     = '0;
    db_out_nxt = '0;
    db_oe_nxt  = 1'b0;
    mem_en_nxt = 1'b0;
    mem_rd_nxt = 1'b0;
    io_en_nxt  = 2'b00;
    io_rd_nxt  = 1'b0;
    hreq_nxt   = (state_nxt == ST_HOLD) || (state_nxt == ST_READ) ||
                 (state_nxt == ST_WRITE);
    busy_nxt   = (state_nxt != ST_IDLE);
    tc_nxt     = (state_nxt == ST_DONE);

    case (state_nxt)
      ST_READ: begin
        dack_nxt = m2m ? 2'b00 : gnt_nxt;
        if (mem_src) begin
          mem_en_nxt = 1'b1;
          mem_rd_nxt = 1'b1;
          ab_nxt     = src_nxt;
        end else begin
          io_en_nxt  = gnt_nxt;
          io_rd_nxt  = 1'b1;
        end
      end
      ST_WRITE: begin
        dack_nxt   = m2m ? 2'b00 : gnt_nxt;
        db_out_nxt = data_nxt;
        db_oe_nxt  = 1'b1;
        if (mem_dst) begin
          mem_en_nxt = 1'b1;
          mem_rd_nxt = 1'b0;
          ab_nxt     = dest_nxt;
        end else begin
          io_en_nxt  = gnt_nxt;
          io_rd_nxt  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dack   <= 2'b00;
      hreq   <= 1'b0;
      ab     <= '0;
      db_out <= '0;
      db_oe  <= 1'b0;
      mem_en <= 1'b0;
      mem_rd <= 1'b0;
      io_en  <= 2'b00;
      io_rd  <= 1'b0;
      busy   <= 1'b0;
      tc     <= 1'b0;
    end else begin
      dack   <= dack_nxt;
      hreq   <= hreq_nxt;
      ab     <= ab_nxt;
      db_out <= db_out_nxt;
      db_oe  <= db_oe_nxt;
      mem_en <= mem_en_nxt;
      mem_rd <= mem_rd_nxt;
      io_en  <= io_en_nxt;
      io_rd  <= io_rd_nxt;
      busy   <= busy_nxt;
      tc     <= tc_nxt;
    end
  end

endmodule

// File: tb/tb_dma_transfer_sequencer.sv
// Scoreboard bench for dma_transfer_sequencer: expected bus events are
// queued when a transfer is set up and compared as the DUT drives them.
module tb_dma_transfer_sequencer;
  import dma_pkg::*;

  localparam logic [3:0] K_MW   = 4'd1;
  localparam logic [3:0] K_IOW0 = 4'd2;
  localparam logic [3:0] K_IOW1 = 4'd3;
  localparam logic [3:0] K_IOR0 = 4'd4;
  localparam logic [3:0] K_IOR1 = 4'd5;
  localparam logic [3:0] K_MR   = 4'd6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_we, cfg_we2;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic [1:0] dreq;
  logic       hack, f_hack, hack_block;
  logic [7:0] db_in;
  logic [7:0] f_db_in;

  logic [1:0] dack, f_dack;
  logic       hreq, f_hreq;
  logic [7:0] ab, f_ab, db_out, f_db_out, word_count, f_word_count;
  logic       db_oe, f_db_oe, mem_en, f_mem_en, mem_rd, f_mem_rd;
  logic [1:0] io_en, f_io_en;
  logic       io_rd, f_io_rd, busy, f_busy, tc, f_tc;

  int n_chk = 0;
  int n_pass = 0;
  int hreq_rise = 0;
  int tc_cnt = 0;
  int f_tc_cnt = 0;
  logic hreq_d = 1'b0;
  logic [7:0] io_cnt = 8'd0;
  logic [23:0] q_bus[$];
  logic [1:0]  q_fix[$];

  always #5 clk = ~clk;

  dma_transfer_sequencer #(.AW(8), .DW(8), .ROUND_ROBIN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .dreq(dreq), .dack(dack), .hreq(hreq),
    .hack(hack), .ab(ab), .db_in(db_in), .db_out(db_out), .db_oe(db_oe),
    .mem_en(mem_en), .mem_rd(mem_rd), .io_en(io_en), .io_rd(io_rd),
    .word_count(word_count), .busy(busy), .tc(tc)
  );

  dma_transfer_sequencer #(.AW(8), .DW(8), .ROUND_ROBIN(1'b0)) u_fixed (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we2), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .dreq(dreq), .dack(f_dack), .hreq(f_hreq),
    .hack(f_hack), .ab(f_ab), .db_in(f_db_in), .db_out(f_db_out),
    .db_oe(f_db_oe), .mem_en(f_mem_en), .mem_rd(f_mem_rd), .io_en(f_io_en),
    .io_rd(f_io_rd), .word_count(f_word_count), .busy(f_busy), .tc(f_tc)
  );

  // Processor grants the bus one cycle after each request
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hack   <= 1'b0;
      f_hack <= 1'b0;
    end else begin
      hack   <= hreq & ~hack_block;
      f_hack <= f_hreq;
    end
  end

  // Memory returns addr ^ 0x5A; IO returns 0x40 + words moved so far
  assign db_in   = (mem_en && mem_rd) ? (ab ^ 8'h5A) : (8'h40 + io_cnt);
  assign f_db_in = 8'h00;

  function automatic logic [23:0] ev(input logic oe, input logic [1:0] dk,
                                     input logic [3:0] kind,
                                     input logic [7:0] a, input logic [7:0] d);
    return {1'b0, oe, dk, kind, a, d};
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Bus monitor for the round-robin instance
  always @(negedge clk) begin
    logic [23:0] obs;
    logic        vld;
    if (rst_n) begin
      vld = 1'b1;
      obs = '0;
      if (mem_en)
        obs = ev(db_oe, dack, mem_rd ? K_MR : K_MW, ab, mem_rd ? db_in : db_out);
      else if (io_en == 2'b01)
        obs = ev(db_oe, dack, io_rd ? K_IOR0 : K_IOW0, 8'h00, io_rd ? db_in : db_out);
      else if (io_en == 2'b10)
        obs = ev(db_oe, dack, io_rd ? K_IOR1 : K_IOW1, 8'h00, io_rd ? db_in : db_out);
      else
        vld = 1'b0;
      if (vld) begin
        if (q_bus.size() == 0) check("unexpected_bus_event", 32'(obs), 32'h0);
        else check("bus_event", 32'(obs), 32'(q_bus.pop_front()));
      end
      if (hreq && !hreq_d) hreq_rise++;
      hreq_d = hreq;
      if (tc) tc_cnt++;
      if ((dack != 2'b00) && db_oe) io_cnt = io_cnt + 8'd1;
    end else begin
      hreq_d = 1'b0;
    end
  end

  // Grant monitor for the fixed-priority instance
  always @(negedge clk) begin
    if (rst_n) begin
      if ((f_io_en != 2'b00) && f_io_rd) begin
        if (q_fix.size() == 0) check("fixed_unexpected_grant", 32'(f_io_en), 32'h0);
        else check("fixed_grant", 32'(f_io_en), 32'(q_fix.pop_front()));
      end
      if (f_tc) f_tc_cnt++;
    end
  end

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] d, input bit both);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_we2   = both;
    cfg_addr  = a;
    cfg_wdata = d;
    @(negedge clk);
    cfg_we    = 1'b0;
    cfg_we2   = 1'b0;
  endtask

  task automatic wait_tc(input int target, input string tag);
    int n;
    n = 0;
    while ((tc_cnt < target) && (n < 300)) begin
      @(negedge clk);
      n++;
    end
    if (tc_cnt < target) check({tag, "_timeout"}, 32'(tc_cnt), 32'(target));
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_hreq(input string tag);
    int n;
    n = 0;
    while (!hreq && (n < 50)) begin
      @(negedge clk);
      n++;
    end
    if (!hreq) check({tag, "_hreq_timeout"}, 32'(hreq), 32'h1);
  endtask

  task automatic tally_clear();
    hreq_rise = 0;
    tc_cnt    = 0;
  endtask

  initial begin
    logic [7:0] d0;
    int n;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_we2 = 1'b0; cfg_addr = 2'd0;
    cfg_wdata = 8'd0; dreq = 2'b00; hack_block = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_hreq", 32'(hreq), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_word_count", 32'(word_count), 32'h0);
    check("rst_bus", 32'({dack, ab, mem_en, io_en, db_oe, tc}), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // IO1 -> memory, two words, single-transfer mode
    tally_clear();
    cfg_write(CFG_DEST, 8'h45, 1'b0);
    cfg_write(CFG_CNT, 8'd2, 1'b0);
    cfg_write(CFG_CTRL, 8'h00, 1'b0);
    d0 = 8'h40 + io_cnt;
    q_bus.push_back(ev(1'b0, 2'b01, K_IOR0, 8'h00, d0));
    q_bus.push_back(ev(1'b1, 2'b01, K_MW,   8'h45, d0));
    q_bus.push_back(ev(1'b0, 2'b01, K_IOR0, 8'h00, d0 + 8'd1));
    q_bus.push_back(ev(1'b1, 2'b01, K_MW,   8'h46, d0 + 8'd1));
    dreq = 2'b01;
    wait_tc(1, "io1_to_mem");
    dreq = 2'b00;
    check("io1_hreq_rises", 32'(hreq_rise), 32'd2);
    check("io1_tc_pulses", 32'(tc_cnt), 32'd1);
    check("io1_word_count", 32'(word_count), 32'h0);
    check("io1_queue_empty", 32'(q_bus.size()), 32'h0);

    // memory -> IO2, then one more word to confirm src advanced to 0x61
    tally_clear();
    cfg_write(CFG_SRC, 8'h60, 1'b0);
    cfg_write(CFG_CNT, 8'd1, 1'b0);
    cfg_write(CFG_CTRL, 8'h02, 1'b0);
    q_bus.push_back(ev(1'b0, 2'b10, K_MR,   8'h60, 8'h60 ^ 8'h5A));
    q_bus.push_back(ev(1'b1, 2'b10, K_IOW1, 8'h00, 8'h60 ^ 8'h5A));
    dreq = 2'b10;
    wait_tc(1, "mem_to_io2");
    check("m2io_tc_pulses", 32'(tc_cnt), 32'd1);
    q_bus.push_back(ev(1'b0, 2'b10, K_MR,   8'h61, 8'h61 ^ 8'h5A));
    q_bus.push_back(ev(1'b1, 2'b10, K_IOW1, 8'h00, 8'h61 ^ 8'h5A));
    cfg_write(CFG_CNT, 8'd1, 1'b0);
    wait_tc(2, "mem_to_io2_next");
    dreq = 2'b00;
    check("m2io_queue_empty", 32'(q_bus.size()), 32'h0);

    // Contention: round robin alternates, fixed priority stays on channel 0
    tally_clear();
    cfg_write(CFG_DEST, 8'h20, 1'b1);
    cfg_write(CFG_CTRL, 8'h00, 1'b1);
    cfg_write(CFG_CNT, 8'd4, 1'b1);
    d0 = 8'h40 + io_cnt;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin
        q_bus.push_back(ev(1'b0, 2'b01, K_IOR0, 8'h00, d0 + 8'(i)));
        q_bus.push_back(ev(1'b1, 2'b01, K_MW, 8'h20 + 8'(i), d0 + 8'(i)));
      end else begin
        q_bus.push_back(ev(1'b0, 2'b10, K_IOR1, 8'h00, d0 + 8'(i)));
        q_bus.push_back(ev(1'b1, 2'b10, K_MW, 8'h20 + 8'(i), d0 + 8'(i)));
      end
      q_fix.push_back(2'b01);
    end
    f_tc_cnt = 0;
    dreq = 2'b11;
    n = 0;
    while (((tc_cnt < 1) || (f_tc_cnt < 1)) && (n < 400)) begin
      @(negedge clk);
      n++;
    end
    dreq = 2'b00;
    check("contention_done", 32'({tc_cnt >= 1, f_tc_cnt >= 1}), 32'h3);
    check("rr_queue_empty", 32'(q_bus.size()), 32'h0);
    check("fixed_queue_empty", 32'(q_fix.size()), 32'h0);
    repeat (2) @(negedge clk);

    // mem2mem block copy with continuous hold
    tally_clear();
    cfg_write(CFG_SRC, 8'h10, 1'b0);
    cfg_write(CFG_DEST, 8'h80, 1'b0);
    cfg_write(CFG_CNT, 8'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      q_bus.push_back(ev(1'b0, 2'b00, K_MR, 8'h10 + 8'(i), (8'h10 + 8'(i)) ^ 8'h5A));
      q_bus.push_back(ev(1'b1, 2'b00, K_MW, 8'h80 + 8'(i), (8'h10 + 8'(i)) ^ 8'h5A));
    end
    cfg_write(CFG_CTRL, 8'h05, 1'b0);
    wait_tc(1, "mem2mem");
    check("m2m_hreq_rises", 32'(hreq_rise), 32'd1);
    check("m2m_tc_pulses", 32'(tc_cnt), 32'd1);
    check("m2m_queue_empty", 32'(q_bus.size()), 32'h0);
    cfg_write(CFG_CNT, 8'd1, 1'b0);
    repeat (5) @(negedge clk);
    check("m2m_start_cleared", 32'({busy, hreq}), 32'h0);
    check("m2m_count_kept", 32'(word_count), 32'h1);

    // Destination address wraps past 0xFF
    tally_clear();
    cfg_write(CFG_CTRL, 8'h00, 1'b0);
    cfg_write(CFG_DEST, 8'hFF, 1'b0);
    cfg_write(CFG_CNT, 8'd2, 1'b0);
    d0 = 8'h40 + io_cnt;
    q_bus.push_back(ev(1'b0, 2'b01, K_IOR0, 8'h00, d0));
    q_bus.push_back(ev(1'b1, 2'b01, K_MW,   8'hFF, d0));
    q_bus.push_back(ev(1'b0, 2'b01, K_IOR0, 8'h00, d0 + 8'd1));
    q_bus.push_back(ev(1'b1, 2'b01, K_MW,   8'h00, d0 + 8'd1));
    dreq = 2'b01;
    wait_tc(1, "wrap");
    check("wrap_queue_empty", 32'(q_bus.size()), 32'h0);

    // Zero count: requests ignored
    tally_clear();
    dreq = 2'b11;
    repeat (6) @(negedge clk);
    check("zero_count_no_hreq", 32'(hreq_rise), 32'h0);
    check("zero_count_idle", 32'(busy), 32'h0);
    dreq = 2'b00;

    // Request withdrawn while waiting for hack
    tally_clear();
    hack_block = 1'b1;
    cfg_write(CFG_DEST, 8'h30, 1'b0);
    cfg_write(CFG_CNT, 8'd3, 1'b0);
    dreq = 2'b01;
    wait_hreq("drop");
    repeat (2) @(negedge clk);
    dreq = 2'b00;
    repeat (2) @(negedge clk);
    check("drop_hreq_released", 32'(hreq), 32'h0);
    check("drop_idle", 32'(busy), 32'h0);
    check("drop_count_kept", 32'(word_count), 32'd3);

    // Config writes while busy are ignored
    tally_clear();
    cfg_write(CFG_CNT, 8'd1, 1'b0);
    dreq = 2'b01;
    wait_hreq("busy_cfg");
    cfg_write(CFG_CNT, 8'd9, 1'b0);
    cfg_write(CFG_DEST, 8'h99, 1'b0);
    check("busy_cfg_count", 32'(word_count), 32'h1);
    d0 = 8'h40 + io_cnt;
    q_bus.push_back(ev(1'b0, 2'b01, K_IOR0, 8'h00, d0));
    q_bus.push_back(ev(1'b1, 2'b01, K_MW,   8'h30, d0));
    hack_block = 1'b0;
    wait_tc(1, "busy_cfg");
    dreq = 2'b00;
    check("busy_cfg_queue_empty", 32'(q_bus.size()), 32'h0);

    // Reset asserted during a WRITE cycle
    cfg_write(CFG_DEST, 8'h50, 1'b0);
    cfg_write(CFG_CNT, 8'd2, 1'b0);
    d0 = 8'h40 + io_cnt;
    q_bus.push_back(ev(1'b0, 2'b01, K_IOR0, 8'h00, d0));
    q_bus.push_back(ev(1'b1, 2'b01, K_MW,   8'h50, d0));
    dreq = 2'b01;
    n = 0;
    while (!db_oe && (n < 50)) begin
      @(negedge clk);
      n++;
    end
    check("mid_reset_in_write", 32'(db_oe), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_reset_strobes", 32'({hreq, busy, db_oe, mem_en, mem_rd, io_rd, tc}), 32'h0);
    check("mid_reset_buses", 32'({dack, io_en, ab, db_out}), 32'h0);
    check("mid_reset_count", 32'(word_count), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_reset_idle", 32'({busy, hreq}), 32'h0);
    check("post_reset_queue_empty", 32'(q_bus.size()), 32'h0);
    dreq = 2'b00;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule

// File: doc/dma_transfer_sequencer.md
Name: dma_transfer_sequencer

Overview:
- Single-channel-engine DMA controller that sequences bus transfers between memory and two IO devices, plus memory-to-memory copies.
- Arbitrates the two IO DMA requests (DREQ1/DREQ2) and obtains the bus from the processor via an HREQ/HACK hold handshake.
- Drives address/data/enable strobes for each word and maintains source, destination and word-count registers.
- Sits between the processor, the memory and the two IO blocks inside the DMA top level.

Parameters:
- AW, 8, address bus width.
- DW, 8, data bus width.
- ROUND_ROBIN, 1, 1 = alternate between IO channels on contention; 0 = channel 0 has fixed priority.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_we  in  1  processor configuration write strobe.
- cfg_addr  in  2  register select: 0 = src, 1 = dest, 2 = count, 3 = ctrl.
- cfg_wdata  in  DW  configuration write data.
- dreq  in  2  DMA requests, bit0 = IO1, bit1 = IO2.
- dack  out  2  DMA acknowledges, one-hot.
- hreq  out  1  bus hold request to processor.
- hack  in  1  bus hold acknowledge from processor.
- ab  out  AW  address bus.
- db_in  in  DW  read data from memory or IO.
- db_out  out  DW  write data.
- db_oe  out  1  db_out valid (write cycle).
- mem_en  out  1  memory enable.
- mem_rd  out  1  1 = memory read, 0 = memory write (valid only with mem_en).
- io_en  out  2  IO1/IO2 enable.
- io_rd  out  1  1 = IO read, 0 = IO write.
- word_count  out  AW  remaining word count.
- busy  out  1  FSM not IDLE.
- tc  out  1  terminal count, one-cycle pulse.

Behaviour:
- Reset (async, rst_n = 0): all outputs 0; src, dest, count, ctrl and data_reg cleared; last_grant = 1; FSM to IDLE. Applies immediately, including mid-transfer.
- ctrl register: bit0 = mem2mem, bit1 = dir (0 IO→mem, 1 mem→IO), bit2 = start (mem2mem only; self-clears at DONE).
- Config writes land on the rising edge when cfg_we = 1 and busy = 0. While busy = 1, config writes are ignored.
- FSM states: IDLE, HOLD, READ, WRITE, DONE.
- IDLE → HOLD when count != 0 and either:
  - mem2mem = 1 and start = 1, or
  - mem2mem = 0 and dreq != 0.
  - Arbitration happens in this cycle and the grant is registered.
  - count = 0: all requests are ignored.
- HOLD: hreq = 1. When hack is sampled 1 → READ.
  - IO mode, granted dreq bit drops before hack → IDLE, hreq released, no count change.
  - Waiting for hack has no timeout.
- READ (1 cycle):
  - IO→mem: io_en[g] = 1, io_rd = 1.
  - Memory read (mem→IO or mem2mem): mem_en = 1, mem_rd = 1, ab = src.
  - data_reg captures db_in at the end of the cycle.
- WRITE (1 cycle):
  - db_out = data_reg, db_oe = 1.
  - IO→mem: mem_en = 1, mem_rd = 0, ab = dest.
  - mem→IO: io_en[g] = 1, io_rd = 0.
  - mem2mem: mem write, ab = dest.
  - At the end of the cycle: count decrements; dest increments if memory was written; src increments if memory was read. Addresses wrap mod 2^AW (0xFF+1 = 0x00).
- dack[g] = 1 throughout READ and WRITE in IO modes; dack = 0 in mem2mem.
- After WRITE:
  - Decremented count = 0 → DONE: tc = 1 for one cycle, start cleared, then IDLE.
  - Otherwise, IO mode → IDLE (single-transfer: hreq dropped, re-arbitrate each word).
  - Otherwise, mem2mem → READ directly (block mode: hreq held continuously).
- hreq stays 1 from HOLD through the last WRITE; it is 0 in DONE and IDLE.
- Arbitration:
  - Single request → granted.
  - Both requests, ROUND_ROBIN = 1 → the channel != last_grant wins; last_grant updates on grant.
  - Both requests, ROUND_ROBIN = 0 → channel 0 wins.
- word_count = count register at all times. busy = (state != IDLE).

Decomposition:
- dma_pkg holds:
  - FSM state encoding;
  - cfg_addr constants (CFG_SRC, CFG_DEST, CFG_CNT, CFG_CTRL);
  - ctrl bit indices (CTRL_M2M, CTRL_DIR, CTRL_START).
- One sub-module, dma_arbiter: 2-input arbiter with registered last_grant and the ROUND_ROBIN parameter, one-hot grant output.

Test Plan:
- IO1→mem: dest = 0x45, count = 2, dir = 0, dreq[0] held, hack = hreq delayed 1 cycle, db_in = 0x40 then 0x41 → memory writes 0x40@0x45 and 0x41@0x46; dack[0] high in READ/WRITE; hreq drops between words; tc pulse once; word_count = 0.
- mem→IO2: src = 0x60, count = 1, dir = 1, dreq[1] → mem read at ab = 0x60, then io_en[1] = 1, io_rd = 0 with db_out equal to the read data; src = 0x61; tc pulse.
- Contention: dreq = 2'b11 held, count = 4 → grant order with ROUND_ROBIN = 1 is 0,1,0,1; with ROUND_ROBIN = 0 it is 0,0,0,0.
- mem2mem: src = 0x10, dest = 0x80, count = 3, start = 1 → reads 0x10–0x12 and writes 0x80–0x82 back-to-back; hreq continuous; dack = 0; start self-clears; tc pulse.
- Wrap and boundaries:
  - dest = 0xFF, count = 2 → writes to 0xFF then 0x00.
  - count = 0 with dreq asserted → hreq stays 0.
  - dreq dropped during HOLD → return to IDLE, count unchanged.
  - cfg write while busy → ignored.
- Reset mid-transfer: rst_n = 0 during WRITE → all outputs 0 immediately (no clock edge); registers cleared; after release FSM is IDLE and hreq = 0.
